// File: rtl/ets_phase_sweep_ctrl.sv
// rtl/ets_phase_sweep_ctrl.sv - equivalent-time-sampling phase sweep sequencer driving the MMCM dynamic phase-shift port
module ets_phase_sweep_ctrl #(
    parameter int NUM_STEPS     = 448,
    parameter int ACC_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int PS_TIMEOUT    = 255,
    parameter int CNT_W         = 11,
    parameter int STEP_W        = 16
) (
    input  logic              shifting_clk,
    input  logic              free_run_rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              ps_en,
    output logic              ps_incdec,
    input  logic              ps_done,
    input  logic              cmp_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [STEP_W-1:0] result_step,
    output logic [CNT_W-1:0]  result_count,
    output logic              busy,
    output logic              sweep_done,
    output logic              ps_timeout_err,
    output logic [STEP_W-1:0] phase_pos
);

    // One shared tick counter times the timeout, settle and window phases.
    localparam int TICK_MAX = (ACC_CYCLES > PS_TIMEOUT)
        ? ((ACC_CYCLES > SETTLE_CYCLES) ? ACC_CYCLES : SETTLE_CYCLES)
        : ((PS_TIMEOUT > SETTLE_CYCLES) ? PS_TIMEOUT : SETTLE_CYCLES);
    localparam int TICK_W      = $clog2(TICK_MAX + 1);
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_SETTLE    = 3'd3,
        S_ACCUM     = 3'd4,
        S_REPORT    = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TICK_W-1:0]   tick;
    logic [CNT_W-1:0]    acc;
    logic [STEP_W-1:0]   step;
    logic                last_step;
    logic                timeout_hit;
    logic                settle_end;
    logic                window_end;

    assign ps_incdec   = 1'b1;
    assign last_step   = (step == STEP_W'(NUM_STEPS - 1));
    assign settle_end  = (tick == TICK_W'(SETTLE_LAST));
    assign window_end  = (tick == TICK_W'(ACC_CYCLES));
    assign timeout_hit = (state == S_WAIT_DONE) && !abort && !ps_done
                         && (tick == TICK_W'(PS_TIMEOUT - 1));

    always_ff @(posedge shifting_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state_nxt = S_ACCUM;
                end
                S_SHIFT: begin
                    state_nxt = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (ps_done) begin
                        state_nxt = (SETTLE_CYCLES == 0) ? S_ACCUM : S_SETTLE;
                    end else if (timeout_hit) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_end) state_nxt = S_ACCUM;
                end
                S_ACCUM: begin
                    if (window_end) state_nxt = S_REPORT;
                end
                S_REPORT: begin
                    if (result_ready) state_nxt = last_step ? S_FINISH : S_SHIFT;
                end
                S_FINISH: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // abort masks the strobes in the same cycle so no shift, transfer or done leaks out.
    always_comb begin
        ps_en        = 1'b0;
        result_valid = 1'b0;
        sweep_done   = 1'b0;
        busy         = (state != S_IDLE);
        if (!abort) begin
            case (state)
                S_SHIFT:  ps_en        = 1'b1;
                S_REPORT: result_valid = 1'b1;
                S_FINISH: sweep_done   = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge shifting_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            tick           <= '0;
            acc            <= '0;
            step           <= '0;
            result_step    <= '0;
            result_count   <= '0;
            ps_timeout_err <= 1'b0;
            phase_pos      <= '0;
        end else begin
            if (state_nxt != state) begin
                tick <= '0;
            end else if (state == S_WAIT_DONE || state == S_SETTLE || state == S_ACCUM) begin
                tick <= tick + TICK_W'(1);
            end

            // Tick 0 of ACCUM is the entry cycle; the window is ticks 1..ACC_CYCLES.
            if (state_nxt == S_ACCUM && state != S_ACCUM) begin
                acc <= '0;
            end else if (state == S_ACCUM && tick != '0) begin
                acc <= acc + CNT_W'(cmp_data);
            end

            if (state == S_ACCUM && state_nxt == S_REPORT) begin
                result_count <= acc + CNT_W'(cmp_data);
                result_step  <= step;
            end

            if (state == S_IDLE && state_nxt == S_ACCUM) begin
                step           <= '0;
                ps_timeout_err <= 1'b0;
            end else if (state == S_REPORT && state_nxt == S_SHIFT) begin
                step <= step + STEP_W'(1);
            end

            if (timeout_hit) begin
                ps_timeout_err <= 1'b1;
            end

            if (ps_en) begin
                phase_pos <= phase_pos + STEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ets_phase_sweep_ctrl.sv
// tb/tb_ets_phase_sweep_ctrl.sv - self-checking bench for ets_phase_sweep_ctrl
module tb_ets_phase_sweep_ctrl;

    localparam int N    = 4;
    localparam int ACC  = 8;
    localparam int S    = 2;
    localparam int T    = 255;
    localparam int CW   = 4;
    localparam int SW   = 16;
    localparam int MAXC = 2048;

    logic          shifting_clk   = 1'b0;
    logic          free_run_rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, ps_done = 1'b0, cmp_data = 1'b0, result_ready = 1'b0;
    logic          ps_en, ps_incdec, result_valid, busy, sweep_done, ps_timeout_err;
    logic [SW-1:0] result_step, phase_pos;
    logic [CW-1:0] result_count;

    logic          start2 = 1'b0, abort2 = 1'b0, ps_done2 = 1'b0, cmp2 = 1'b0, ready2 = 1'b0;
    logic          en2, incdec2, valid2, busy2, done2, err2;
    logic [SW-1:0] step2, pos2;
    logic [CW-1:0] count2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 shifting_clk = ~shifting_clk;

    ets_phase_sweep_ctrl #(
        .NUM_STEPS(N), .ACC_CYCLES(ACC), .SETTLE_CYCLES(S), .PS_TIMEOUT(T), .CNT_W(CW), .STEP_W(SW)
    ) u_dut (
        .shifting_clk(shifting_clk), .free_run_rst_n(free_run_rst_n),
        .start(start), .abort(abort), .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
        .cmp_data(cmp_data), .result_valid(result_valid), .result_ready(result_ready),
        .result_step(result_step), .result_count(result_count), .busy(busy),
        .sweep_done(sweep_done), .ps_timeout_err(ps_timeout_err), .phase_pos(phase_pos)
    );

    ets_phase_sweep_ctrl #(
        .NUM_STEPS(1), .ACC_CYCLES(ACC), .SETTLE_CYCLES(0), .PS_TIMEOUT(T), .CNT_W(CW), .STEP_W(SW)
    ) u_dut_one (
        .shifting_clk(shifting_clk), .free_run_rst_n(free_run_rst_n),
        .start(start2), .abort(abort2), .ps_en(en2), .ps_incdec(incdec2), .ps_done(ps_done2),
        .cmp_data(cmp2), .result_valid(valid2), .result_ready(ready2),
        .result_step(step2), .result_count(count2), .busy(busy2),
        .sweep_done(done2), .ps_timeout_err(err2), .phase_pos(pos2)
    );

    typedef struct {
        bit          start, abort, ps_done, cmp, ready;
        bit          busy, en, valid, done, err;
        bit [SW-1:0] step, pos;
        bit [CW-1:0] count;
    } vec_t;

    vec_t vec [MAXC];
    bit   wait_c  [MAXC];
    bit   err_set [MAXC];
    bit   err_clr [MAXC];
    int   acc_entry [N];
    int   nv;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Timeline of one sweep from the rules: window after entry, handshake, shift, ps_done delay, settle.
    task automatic plan_sweep(input int cs, input int mode, input int hold, input int dmin,
                              input int dmax, input int to_step, output int end_c);
        int e, v, a, p, d, w, cnt;
        vec[cs].start   = 1'b1;
        err_clr[cs + 1] = 1'b1;
        e     = cs + 1;
        end_c = cs + 1;
        for (int k = 0; k < N; k++) begin
            acc_entry[k] = e;
            cnt = 0;
            for (int i = 1; i <= ACC; i++) begin
                if (mode == 1)      vec[e + i].cmp = 1'b1;
                else if (mode == 2) vec[e + i].cmp = (i % 2 == 1);
                else                vec[e + i].cmp = 1'($urandom_range(0, 1));
                cnt += int'(vec[e + i].cmp);
            end
            for (int c = e; c <= e + ACC; c++) vec[c].busy = 1'b1;
            v = e + ACC + 1;
            w = (hold >= 0) ? hold : int'($urandom_range(0, 4));
            a = v + w;
            for (int c = v; c <= a; c++) begin
                vec[c].busy  = 1'b1;
                vec[c].valid = 1'b1;
                vec[c].step  = SW'(k);
                vec[c].count = CW'(cnt);
                vec[c].ready = (c == a);
            end
            if (k == N - 1) begin
                vec[a + 1].busy = 1'b1;
                vec[a + 1].done = 1'b1;
                end_c = a + 2;
                return;
            end
            p = a + 1;
            vec[p].busy = 1'b1;
            vec[p].en   = 1'b1;
            if (k + 1 == to_step) begin
                for (int c = p + 1; c <= p + T; c++) begin
                    vec[c].busy = 1'b1;
                    wait_c[c]   = 1'b1;
                end
                err_set[p + T + 1] = 1'b1;
                end_c = p + T + 1;
                return;
            end
            d = int'($urandom_range(dmax, dmin));
            for (int c = p + 1; c <= p + d; c++) begin
                vec[c].busy = 1'b1;
                wait_c[c]   = 1'b1;
            end
            vec[p + d].ps_done = 1'b1;
            for (int c = p + d + 1; c <= p + d + S; c++) vec[c].busy = 1'b1;
            e = p + d + S + 1;
        end
    endtask

    task automatic apply_abort(input int x, input int old_end, output int new_end);
        vec[x].abort = 1'b1;
        vec[x].en    = 1'b0;
        vec[x].valid = 1'b0;
        vec[x].done  = 1'b0;
        for (int c = x + 1; c < old_end; c++) begin
            vec[c].busy  = 1'b0;
            vec[c].en    = 1'b0;
            vec[c].valid = 1'b0;
            vec[c].done  = 1'b0;
            wait_c[c]    = 1'b0;
            err_set[c]   = 1'b0;
        end
        new_end = x + 1;
    endtask

    initial begin
        int          cy, endc;
        bit          err;
        bit [SW-1:0] pos;

        for (int c = 0; c < MAXC; c++) begin
            vec[c]       = '{default: '0};
            vec[c].cmp   = 1'($urandom_range(0, 1));
            vec[c].ready = 1'($urandom_range(0, 1));
            wait_c[c]    = 1'b0;
            err_set[c]   = 1'b0;
            err_clr[c]   = 1'b0;
        end

        cy = 2;
        plan_sweep(cy, 1, 0, 5, 5, -1, endc);     cy = endc + 3;
        plan_sweep(cy, 2, 10, 1, 8, -1, endc);    cy = endc + 2;
        plan_sweep(cy, 0, -1, 1, 8, -1, endc);    cy = endc + 4;
        plan_sweep(cy, 0, -1, 1, 8, 1, endc);     cy = endc + 2;
        vec[cy].start = 1'b1;
        vec[cy].abort = 1'b1;
        cy = cy + 3;
        plan_sweep(cy, 0, -1, 1, 8, -1, endc);
        apply_abort(acc_entry[2] + 3, endc, endc); cy = endc + 2;
        plan_sweep(cy, 0, 1, 1, 4, -1, endc);     cy = endc + 3;
        nv = cy;

        // Spurious traffic the block must ignore.
        for (int c = 0; c < nv; c++) begin
            if (vec[c].busy && $urandom_range(0, 7) == 0) vec[c].start = 1'b1;
            if (!wait_c[c] && !vec[c].ps_done && $urandom_range(0, 7) == 0) vec[c].ps_done = 1'b1;
            if (!vec[c].busy && !vec[c].start && $urandom_range(0, 15) == 0) vec[c].abort = 1'b1;
        end

        err = 1'b0;
        pos = '0;
        for (int c = 0; c < nv; c++) begin
            if (err_set[c]) err = 1'b1;
            if (err_clr[c]) err = 1'b0;
            vec[c].err = err;
            vec[c].pos = pos;
            if (vec[c].en) pos = pos + SW'(1);
        end

        #2;
        chk("rst_busy", -1, busy, 0);
        chk("rst_ps_en", -1, ps_en, 0);
        chk("rst_incdec", -1, ps_incdec, 1);
        chk("rst_valid", -1, result_valid, 0);
        chk("rst_step", -1, result_step, 0);
        chk("rst_count", -1, result_count, 0);
        chk("rst_done", -1, sweep_done, 0);
        chk("rst_err", -1, ps_timeout_err, 0);
        chk("rst_pos", -1, phase_pos, 0);
        chk("rst_one_busy", -1, busy2, 0);
        #10 free_run_rst_n = 1'b1;

        for (int c = 0; c < nv; c++) begin
            @(posedge shifting_clk);
            #1;
            start        = vec[c].start;
            abort        = vec[c].abort;
            ps_done      = vec[c].ps_done;
            cmp_data     = vec[c].cmp;
            result_ready = vec[c].ready;
            @(negedge shifting_clk);
            chk("busy", c, busy, vec[c].busy);
            chk("ps_en", c, ps_en, vec[c].en);
            chk("ps_incdec", c, ps_incdec, 1);
            chk("result_valid", c, result_valid, vec[c].valid);
            chk("sweep_done", c, sweep_done, vec[c].done);
            chk("ps_timeout_err", c, ps_timeout_err, vec[c].err);
            chk("phase_pos", c, phase_pos, vec[c].pos);
            if (vec[c].valid) begin
                chk("result_step", c, result_step, vec[c].step);
                chk("result_count", c, result_count, vec[c].count);
            end
        end
        start = 1'b0; abort = 1'b0; ps_done = 1'b0; result_ready = 1'b0;

        // Single-point sweep: one result, no shift, done right after acceptance.
        @(posedge shifting_clk);
        #1 start2 = 1'b1; cmp2 = 1'b1; ready2 = 1'b0;
        @(negedge shifting_clk);
        chk("one_busy_start", 0, busy2, 0);
        for (int c = 1; c <= ACC + 7; c++) begin
            @(posedge shifting_clk);
            #1;
            start2 = (c == 4);
            ready2 = (c == ACC + 5);
            @(negedge shifting_clk);
            chk("one_valid", c, valid2, (c >= ACC + 2 && c <= ACC + 5));
            chk("one_ps_en", c, en2, 0);
            chk("one_done", c, done2, (c == ACC + 6));
            chk("one_busy", c, busy2, (c <= ACC + 6));
            if (c >= ACC + 2 && c <= ACC + 5) begin
                chk("one_step", c, step2, 0);
                chk("one_count", c, count2, ACC);
            end
        end
        chk("one_pos", ACC + 7, pos2, 0);

        // Asynchronous reset in the middle of a sweep.
        @(posedge shifting_clk);
        #1 start = 1'b1;
        @(posedge shifting_clk);
        #1 start = 1'b0;
        repeat (4) @(posedge shifting_clk);
        #3 free_run_rst_n = 1'b0;
        #1;
        chk("arst_busy", -2, busy, 0);
        chk("arst_valid", -2, result_valid, 0);
        chk("arst_ps_en", -2, ps_en, 0);
        chk("arst_pos", -2, phase_pos, 0);
        chk("arst_err", -2, ps_timeout_err, 0);
        chk("arst_count", -2, result_count, 0);
        #4 free_run_rst_n = 1'b1;
        repeat (2) @(posedge shifting_clk);
        @(negedge shifting_clk);
        chk("arst_idle_after", -2, busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
